// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: free-running divider, HALT/STEP/SLOW/FAST modes,
// debounced single-step button, PC breakpoint with resume.
module cpu_clk_ctrl #(
   parameter int unsigned DIV_W    = 32,
   parameter int unsigned FAST_BIT = 1,
   parameter int unsigned SLOW_BIT = 24,
   parameter int unsigned DB_MAX   = 1000000,
   parameter int unsigned PC_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode_sel,
   input  logic              step_btn,
   input  logic              resume,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_addr,
   input  logic [PC_W-1:0]   pc,
   output logic              cpu_ce,
   output logic              halted,
   output logic              at_break,
   output logic [31:0]       tick_cnt,
   output logic [DIV_W-1:0]  clkdiv
);

   localparam int unsigned DB_W = (DB_MAX > 2) ? $clog2(DB_MAX) : 1;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b01;
   localparam logic [1:0] MODE_SLOW = 2'b10;
   localparam logic [1:0] MODE_FAST = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BRK, ST_RESUME} state_t;

   state_t            state, state_nxt;
   logic [1:0]        mode_s1, mode_s2;
   logic              btn_s1, btn_s2;
   logic              prev_f, prev_s;
   logic              tick_f, tick_s, sel_tick;
   logic [DB_W-1:0]   db_cnt;
   logic              db_level, db_prev;
   logic              step_pulse;
   logic              run_mode, bp_hit;
   logic              ce_nxt;

   // Two-flop synchronisers for the asynchronous switch and button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_s1 <= MODE_HALT;
         mode_s2 <= MODE_HALT;
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
      end else begin
         mode_s1 <= mode_sel;
         mode_s2 <= mode_s1;
         btn_s1  <= step_btn;
         btn_s2  <= btn_s1;
      end
   end

   // Free-running divider and rising-edge detectors on the tick bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkdiv <= '0;
         prev_f <= 1'b0;
         prev_s <= 1'b0;
      end else begin
         clkdiv <= clkdiv + DIV_W'(1);
         prev_f <= clkdiv[FAST_BIT];
         prev_s <= clkdiv[SLOW_BIT];
      end
   end

   assign tick_f = clkdiv[FAST_BIT] & ~prev_f;
   assign tick_s = clkdiv[SLOW_BIT] & ~prev_s;

   always_comb begin
      sel_tick = 1'b0;
      case (mode_s2)
         MODE_FAST: sel_tick = tick_f;
         MODE_SLOW: sel_tick = tick_s;
         default:   sel_tick = 1'b0;
      endcase
   end

   // Debounce: level follows the input only after DB_MAX consecutive differing clks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
      end else begin
         db_prev <= db_level;
         if (btn_s2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DB_MAX - 1)) begin
            db_level <= btn_s2;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign step_pulse = db_level & ~db_prev;
   assign run_mode   = mode_s2[1];
   assign bp_hit     = bp_en && (pc == bp_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state: leaving a run mode outranks every other event
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (run_mode) state_nxt = ST_RUN;
         ST_RUN:    if (!run_mode) state_nxt = ST_IDLE;
                    else if (sel_tick && bp_hit) state_nxt = ST_BRK;
         ST_BRK:    if (!run_mode) state_nxt = ST_IDLE;
                    else if (resume) state_nxt = ST_RESUME;
         ST_RESUME: if (!run_mode) state_nxt = ST_IDLE;
                    else if (sel_tick) state_nxt = ST_RUN;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Tick decision; RESUME issues the breakpoint instruction without the bp check
   always_comb begin
      ce_nxt = 1'b0;
      case (state)
         ST_IDLE:   ce_nxt = (mode_s2 == MODE_STEP) && step_pulse;
         ST_RUN:    ce_nxt = run_mode && sel_tick && !bp_hit;
         ST_RESUME: ce_nxt = run_mode && sel_tick;
         default:   ce_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_ce   <= 1'b0;
         tick_cnt <= '0;
         halted   <= 1'b1;
         at_break <= 1'b0;
      end else begin
         cpu_ce   <= ce_nxt;
         tick_cnt <= tick_cnt + 32'(cpu_ce);
         halted   <= (state_nxt == ST_IDLE) || (state_nxt == ST_BRK);
         at_break <= (state_nxt == ST_BRK);
      end
   end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: vector table, corner-case sequences and random stimulus
// compared every cycle against a behavioural model.
module tb_cpu_clk_ctrl;

   localparam int unsigned FB  = 1;
   localparam int unsigned SB  = 4;
   localparam int unsigned DBM = 4;
   localparam int unsigned FP  = 2 ** (FB + 1);
   localparam int unsigned SP  = 2 ** (SB + 1);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  mode_sel = 2'b00;
   logic        step_btn = 1'b0;
   logic        resume = 1'b0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'h0;
   logic [31:0] pc = 32'h0;
   logic        cpu_ce, halted, at_break;
   logic [31:0] tick_cnt;
   logic [31:0] clkdiv;

   int checks = 0;
   int errors = 0;
   int ce_seen = 0;
   logic prev_ce = 1'b0;
   logic mon_en = 1'b0;

   cpu_clk_ctrl #(
      .DIV_W(32), .FAST_BIT(FB), .SLOW_BIT(SB), .DB_MAX(DBM), .PC_W(32)
   ) dut (
      .clk(clk), .rst(rst), .mode_sel(mode_sel), .step_btn(step_btn),
      .resume(resume), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .cpu_ce(cpu_ce), .halted(halted), .at_break(at_break),
      .tick_cnt(tick_cnt), .clkdiv(clkdiv)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: synchronisers as 2-deep queues, ticks from divider arithmetic
   typedef enum {M_IDLE, M_RUN, M_BRK, M_RES} mst_t;
   mst_t        m_st;
   int unsigned m_div;
   int unsigned m_cnt;
   logic        m_ce;
   logic [1:0]  mq[$];
   logic        bq[$];
   logic        m_lvl, m_lvl_prev;
   int          m_run;

   task automatic model_reset();
      m_st = M_IDLE; m_div = 0; m_cnt = 0; m_ce = 1'b0;
      mq = '{2'd0, 2'd0};
      bq = '{1'b0, 1'b0};
      m_lvl = 1'b0; m_lvl_prev = 1'b0; m_run = 0;
   endtask

   task automatic model_step();
      logic [1:0] md;
      logic b, fast, slow, tk, pulse, hit, nce;
      md = mq.pop_front(); mq.push_back(mode_sel);
      b  = bq.pop_front(); bq.push_back(step_btn);
      fast  = (m_div % FP) == FP / 2;
      slow  = (m_div % SP) == SP / 2;
      pulse = m_lvl && !m_lvl_prev;
      m_lvl_prev = m_lvl;
      if (b != m_lvl) begin
         m_run++;
         if (m_run == int'(DBM)) begin m_lvl = b; m_run = 0; end
      end else m_run = 0;
      tk  = (md == 2'd3) ? fast : (md == 2'd2) ? slow : 1'b0;
      hit = bp_en && (pc == bp_addr);
      nce = 1'b0;
      case (m_st)
         M_IDLE: if (md == 2'd1 && pulse) nce = 1'b1;
                 else if (md >= 2'd2) m_st = M_RUN;
         M_RUN:  if (md < 2'd2) m_st = M_IDLE;
                 else if (tk) begin
                    if (hit) m_st = M_BRK; else nce = 1'b1;
                 end
         M_BRK:  if (md < 2'd2) m_st = M_IDLE;
                 else if (resume) m_st = M_RES;
         M_RES:  if (md < 2'd2) m_st = M_IDLE;
                 else if (tk) begin nce = 1'b1; m_st = M_RUN; end
         default: m_st = M_IDLE;
      endcase
      m_cnt = m_cnt + int'(m_ce);
      m_ce  = nce;
      m_div = m_div + 1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // Per-cycle comparison against the model, plus pulse-width check
   always @(negedge clk) begin
      if (mon_en) begin
         chk("cpu_ce", cpu_ce, m_ce);
         chk("halted", halted, (m_st == M_IDLE) || (m_st == M_BRK));
         chk("at_break", at_break, m_st == M_BRK);
         chk("tick_cnt", tick_cnt, m_cnt);
         chk("clkdiv", clkdiv, m_div);
         if (cpu_ce) begin
            ce_seen++;
            chk("ce_width", prev_ce, 1'b0);
         end
         prev_ce = cpu_ce;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic        bp_en;
      logic [31:0] bp_addr;
      logic [31:0] pc;
      int          settle;
      int          win;
      int          exp_ce;
      logic        exp_halted;
      logic        exp_brk;
   } vec_t;

   vec_t vt[9];
   int   base;
   int   n;

   initial begin
      vt[0] = '{2'b00, 1'b0, 32'h10, 32'h00, 4, 16, 0, 1'b1, 1'b0};
      vt[1] = '{2'b11, 1'b0, 32'h10, 32'h00, 6, 64, 16, 1'b0, 1'b0};
      vt[2] = '{2'b10, 1'b0, 32'h10, 32'h00, 6, 128, 4, 1'b0, 1'b0};
      vt[3] = '{2'b11, 1'b0, 32'h10, 32'h00, 6, 32, 8, 1'b0, 1'b0};
      vt[4] = '{2'b11, 1'b1, 32'h10, 32'h10, 8, 16, 0, 1'b1, 1'b1};
      vt[5] = '{2'b01, 1'b1, 32'h10, 32'h10, 6, 16, 0, 1'b1, 1'b0};
      vt[6] = '{2'b10, 1'b1, 32'h10, 32'h20, 6, 64, 2, 1'b0, 1'b0};
      vt[7] = '{2'b00, 1'b0, 32'h10, 32'h20, 6, 16, 0, 1'b1, 1'b0};
      vt[8] = '{2'b11, 1'b0, 32'h10, 32'h10, 6, 32, 8, 1'b0, 1'b0};

      #1 rst = 1'b1;
      cyc(1);
      chk("rst_cpu_ce", cpu_ce, 1'b0);
      chk("rst_halted", halted, 1'b1);
      chk("rst_at_break", at_break, 1'b0);
      chk("rst_tick_cnt", tick_cnt, 32'h0);
      chk("rst_clkdiv", clkdiv, 32'h0);
      mon_en = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(1);

      for (int i = 0; i < 9; i++) begin
         mode_sel = vt[i].mode; bp_en = vt[i].bp_en;
         bp_addr = vt[i].bp_addr; pc = vt[i].pc;
         cyc(vt[i].settle);
         base = ce_seen;
         cyc(vt[i].win);
         chk($sformatf("vec%0d_ce_count", i), ce_seen - base, vt[i].exp_ce);
         chk($sformatf("vec%0d_halted", i), halted, vt[i].exp_halted);
         chk($sformatf("vec%0d_at_break", i), at_break, vt[i].exp_brk);
      end

      // Single step with a bouncing button
      mode_sel = 2'b00; bp_en = 1'b0; pc = 32'h0;
      do_reset();
      mode_sel = 2'b01;
      cyc(6);
      base = ce_seen;
      step_btn = 1'b1; cyc(1);
      step_btn = 1'b0; cyc(1);
      step_btn = 1'b1; cyc(6);
      step_btn = 1'b0; cyc(12);
      chk("step_one_ce", ce_seen - base, 1);
      chk("step_tick_cnt", tick_cnt, 32'h1);

      // Button press outside STEP is discarded
      mode_sel = 2'b00;
      cyc(6);
      base = ce_seen;
      step_btn = 1'b1; cyc(10);
      mode_sel = 2'b01; cyc(6);
      step_btn = 1'b0; cyc(10);
      chk("halt_btn_ignored", ce_seen - base, 0);

      // Breakpoint then resume
      mode_sel = 2'b00;
      do_reset();
      bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h10; mode_sel = 2'b11;
      base = ce_seen;
      n = 0;
      while (!at_break && n < 40) begin cyc(1); n++; end
      chk("bp_reached", at_break, 1'b1);
      chk("bp_halted", halted, 1'b1);
      chk("bp_no_ce", ce_seen - base, 0);
      cyc(6);
      chk("bp_hold", at_break, 1'b1);
      resume = 1'b1; cyc(1); resume = 1'b0;
      n = 0;
      while (!cpu_ce && n < 10) begin cyc(1); n++; end
      chk("resume_ce", cpu_ce, 1'b1);
      chk("resume_at_break", at_break, 1'b0);
      chk("resume_halted", halted, 1'b0);
      pc = 32'h14;
      cyc(16);
      chk("resume_run_ce", ce_seen - base, 5);
      chk("resume_run_brk", at_break, 1'b0);

      // Switching to HALT stops ce within 3 clk
      bp_en = 1'b0;
      cyc(8);
      mode_sel = 2'b00;
      cyc(2);
      base = ce_seen;
      cyc(8);
      chk("halt_stop_ce", ce_seen - base, 0);
      chk("halt_stop_halted", halted, 1'b1);

      // Async reset with a tick pending
      mode_sel = 2'b11;
      cyc(8);
      n = 0;
      while (clkdiv[1:0] != 2'd2 && n < 8) begin cyc(1); n++; end
      chk("pre_rst_running", halted, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_rst_ce", cpu_ce, 1'b0);
      chk("async_rst_tick_cnt", tick_cnt, 32'h0);
      chk("async_rst_halted", halted, 1'b1);
      cyc(1);
      chk("async_rst_ce_dropped", cpu_ce, 1'b0);
      mode_sel = 2'b00;
      cyc(1);
      rst = 1'b0;
      cyc(2);

      // tick_cnt wrap
      force dut.tick_cnt = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      cyc(1);
      release dut.tick_cnt;
      cyc(1);
      mode_sel = 2'b11;
      base = ce_seen;
      n = 0;
      while ((ce_seen - base) < 2 && n < 40) begin cyc(1); n++; end
      cyc(1);
      chk("wrap_ce_count", ce_seen - base, 2);
      chk("wrap_tick_cnt", tick_cnt, 32'h0);

      // Random stimulus against the model
      bp_addr = 32'h10;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(39, 0) == 0) mode_sel = 2'($urandom_range(3, 0));
         if ($urandom_range(5, 0) == 0) step_btn = ~step_btn;
         if ($urandom_range(49, 0) == 0) bp_en = ~bp_en;
         if ($urandom_range(7, 0) == 0) begin
            case ($urandom_range(2, 0))
               0:       pc = 32'h10;
               1:       pc = 32'h14;
               default: pc = 32'h20;
            endcase
         end
         resume = ($urandom_range(9, 0) == 0);
         cyc(1);
      end
      resume = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
